// File: rtl/i3c_pkg.sv
// Shared types and constants for the I3C SDR transfer scheduler.
package i3c_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACTIVE = 2'd1;
   localparam state_t ST_DONE   = 2'd2;

   localparam logic [7:0] TX_UNDERFLOW_BYTE = 8'hFF;
   localparam logic [7:0] RX_EMPTY_BYTE     = 8'h00;

endpackage

// File: rtl/i3c_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
module i3c_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  din_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o,
   output logic [W-1:0]  head_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/i3c_xfer_sched.sv
// Byte-level transfer scheduler: framing FSM, RX/TX FIFOs and sticky error flags.
module i3c_xfer_sched
   import i3c_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i3c_en,
   input  logic          start_detected,
   input  logic          stop_detected,
   input  logic          eng_rx_valid,
   input  logic [7:0]    eng_rx_data,
   input  logic          eng_tx_req,
   output logic [7:0]    eng_tx_data,
   output logic          eng_tx_valid,
   input  logic          reg_wr_en,
   input  logic [7:0]    reg_wr_data,
   input  logic          reg_rd_en,
   output logic [7:0]    reg_rd_data,
   output logic [AW:0]   rx_count,
   output logic [AW:0]   tx_count,
   output logic          rx_ovf,
   output logic          tx_ovf,
   output logic          tx_udf,
   input  logic          clr_err,
   output logic          busy,
   output logic          xfer_done,
   output logic [1:0]    dbg_state_o
);

   state_t state_q, state_d;
   logic   rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, tx_udf_q, tx_udf_d;
   logic   active, flush;
   logic   rx_push, rx_pop, tx_push, tx_pop;
   logic   rx_full, rx_empty, tx_full, tx_empty;
   logic [7:0] rx_head, tx_head;

   assign active = (state_q == ST_ACTIVE);
   assign flush  = !i3c_en;

   // Engine and CPU strobes are single-cycle requests with no back-pressure:
   // the FIFO status outputs are the only "ready", and a strobe that cannot be
   // honoured is dropped (overflow) or answered with a filler byte (underflow).
   assign rx_push = i3c_en && eng_rx_valid && active;
   assign rx_pop  = i3c_en && reg_rd_en;
   assign tx_push = i3c_en && reg_wr_en;
   assign tx_pop  = i3c_en && eng_tx_req && active;

   i3c_sync_fifo #(.DEPTH(DEPTH), .W(8)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .push_i(rx_push), .pop_i(rx_pop), .din_i(eng_rx_data),
      .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count), .head_o(rx_head)
   );

   i3c_sync_fifo #(.DEPTH(DEPTH), .W(8)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .push_i(tx_push), .pop_i(tx_pop), .din_i(reg_wr_data),
      .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count), .head_o(tx_head)
   );

   assign eng_tx_valid = !tx_empty;
   assign eng_tx_data  = tx_empty ? TX_UNDERFLOW_BYTE : tx_head;
   assign reg_rd_data  = rx_empty ? RX_EMPTY_BYTE : rx_head;
   assign busy         = (state_q != ST_IDLE);
   assign xfer_done    = (state_q == ST_DONE);
   assign dbg_state_o  = state_q;
   assign rx_ovf       = rx_ovf_q;
   assign tx_ovf       = tx_ovf_q;
   assign tx_udf       = tx_udf_q;

   always_comb begin
      state_d = state_q;
      if (!i3c_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            // STOP beats a coincident START, so IDLE never leaves on a START+STOP pair.
            ST_IDLE:   if (start_detected && !stop_detected) state_d = ST_ACTIVE;
            ST_ACTIVE: if (stop_detected) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rx_ovf_d = 1'b0;
      tx_ovf_d = 1'b0;
      tx_udf_d = 1'b0;
      if (i3c_en) begin
         // A set in the same cycle as clr_err wins.
         rx_ovf_d = (rx_push && rx_full && !rx_pop) || (rx_ovf_q && !clr_err);
         tx_ovf_d = (tx_push && tx_full && !tx_pop) || (tx_ovf_q && !clr_err);
         tx_udf_d = (tx_pop && tx_empty) || (tx_udf_q && !clr_err);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rx_ovf_q <= 1'b0;
         tx_ovf_q <= 1'b0;
         tx_udf_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rx_ovf_q <= rx_ovf_d;
         tx_ovf_q <= tx_ovf_d;
         tx_udf_q <= tx_udf_d;
      end
   end

endmodule
